life_frame_streamer: RTL and testbench

//  Downstream of the Game-of-Life engine. Accepts one flattened 8x8 generation (64 bits) and maps each

---
 rtl/life_frame_streamer_pkg.sv | 24 ++
 rtl/life_frame_streamer_if.sv | 13 +
 rtl/life_frame_streamer_bit_tx.sv | 41 ++++
 rtl/life_frame_streamer.sv | 134 +++++++++++++
 tb/tb_life_frame_streamer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_frame_streamer_pkg.sv
// Shared definitions for the Game-of-Life LED frame streamer: grid geometry,
// the GRB colour type, the streamer FSM states and a cell colour helper.
package life_frame_streamer_pkg;

  localparam int GRID_DIM       = 8;
  localparam int CELLS          = GRID_DIM * GRID_DIM;
  localparam int BITS_PER_PIXEL = 24;

  typedef logic [BITS_PER_PIXEL-1:0] grb_t;

  typedef enum logic [2:0] {
    IDLE,
    BIT,
    LATCH,
    HOLD,
    DONE
  } streamer_state_t;

  // Map one cell's alive flag onto the colour sent to the panel
  function automatic grb_t cell_colour(input logic alive, input grb_t alive_grb, input grb_t dead_grb);
    return alive ? alive_grb : dead_grb;
  endfunction

endpackage

// File: rtl/life_frame_streamer_if.sv
// Frame handshake between the Game-of-Life engine (master) and the LED
// frame streamer (slave). A frame moves on a clock edge with valid && ready.
interface life_frame_streamer_if;
  import life_frame_streamer_pkg::*;

  logic [CELLS-1:0] frame_in;
  logic             frame_valid;
  logic             frame_ready;

  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave  (input frame_in, input frame_valid, output frame_ready);

endinterface

// File: rtl/life_frame_streamer_bit_tx.sv
// WS2812 single-bit waveform generator. While start is held high it emits
// back-to-back bit periods of T_BIT cycles, holding the line high for T1H or
// T0H cycles depending on cur_bit. bit_last marks the final cycle of a period
// so the caller can present the next bit. The line is registered, so it lags
// bit_cnt by one cycle and never glitches.
module ws2812_bit_tx #(
  parameter int T_BIT = 15,
  parameter int T0H   = 4,
  parameter int T1H   = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic cur_bit,
  output logic led_dout,
  output logic bit_last
);

  localparam int CNT_W = $clog2(T_BIT) + 1;

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] high_len;

  assign high_len = cur_bit ? CNT_W'(T1H) : CNT_W'(T0H);
  assign bit_last = start && (bit_cnt == CNT_W'(T_BIT - 1));

  // Step through the bit period and drive the high/low portion from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      led_dout <= 1'b0;
    end else if (!start) begin
      bit_cnt  <= '0;
      led_dout <= 1'b0;
    end else begin
      led_dout <= (bit_cnt < high_len);
      bit_cnt  <= bit_last ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/life_frame_streamer.sv
// Takes one 8x8 Game-of-Life generation, colours each cell and streams the
// 64 pixels (24 GRB bits each, MSB first) to a WS2812 panel. After the latch
// gap and a hold period that paces the generation rate, frame_done pulses
// for one cycle so the engine can compute the next generation.
module life_frame_streamer
  import life_frame_streamer_pkg::*;
#(
  parameter int   T_BIT     = 15,
  parameter int   T0H       = 4,
  parameter int   T1H       = 10,
  parameter int   T_LATCH   = 3600,
  parameter int   HOLD_CYC  = 6_000_000,
  parameter grb_t ALIVE_GRB = 24'h00_10_00,
  parameter grb_t DEAD_GRB  = 24'h00_00_00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  life_frame_streamer_if.slave   frame_bus,
  output logic                   led_dout,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int PIX_W     = $clog2(CELLS) + 1;
  localparam int PIX_SEL_W = $clog2(CELLS);
  localparam int BIT_W     = $clog2(BITS_PER_PIXEL) + 1;
  localparam int BIT_SEL_W = $clog2(BITS_PER_PIXEL);
  localparam int LATCH_W   = $clog2(T_LATCH) + 1;
  localparam int HOLD_LEN  = (HOLD_CYC == 0) ? 1 : HOLD_CYC;
  localparam int HOLD_W    = $clog2(HOLD_LEN) + 1;

  streamer_state_t      state_q;
  streamer_state_t      state_d;
  logic [CELLS-1:0]     frame_q;
  grb_t                 colour_q;
  logic [PIX_W-1:0]     pixel_idx;
  logic [BIT_W-1:0]     bit_idx;
  logic [LATCH_W-1:0]   latch_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [PIX_SEL_W-1:0] next_sel;
  logic                 accept;
  logic                 tx_start;
  logic                 tx_bit;
  logic                 bit_last;
  logic                 last_bit_of_pixel;
  logic                 last_pixel;

  assign accept                = frame_bus.frame_valid && (state_q == IDLE);
  assign frame_bus.frame_ready = (state_q == IDLE);
  assign busy                  = (state_q != IDLE);
  assign frame_done            = (state_q == DONE);
  assign tx_start              = (state_q == BIT);
  assign tx_bit                = colour_q[bit_idx[BIT_SEL_W-1:0]];
  assign last_bit_of_pixel     = (bit_idx == '0);
  assign last_pixel            = (pixel_idx == PIX_W'(CELLS - 1));
  // Frame bit of the pixel after pixel_idx: bit (CELLS-1) - (pixel_idx+1)
  assign next_sel              = PIX_SEL_W'(CELLS - 2) - pixel_idx[PIX_SEL_W-1:0];

  ws2812_bit_tx #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tx_start),
    .cur_bit  (tx_bit),
    .led_dout (led_dout),
    .bit_last (bit_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The line trails the FSM by one flop, so LATCH lasts
  // T_LATCH+1 cycles to give T_LATCH fully low cycles after the last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_bus.frame_valid) state_d = BIT;
      BIT:     if (bit_last && last_bit_of_pixel && last_pixel) state_d = LATCH;
      LATCH:   if (latch_cnt == LATCH_W'(T_LATCH)) state_d = HOLD;
      HOLD:    if (hold_cnt == HOLD_W'(HOLD_LEN - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame capture, pixel/bit walking and the latch/hold timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      colour_q  <= '0;
      pixel_idx <= '0;
      bit_idx   <= '0;
      latch_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      if (state_q != LATCH) latch_cnt <= '0;
      if (state_q != HOLD)  hold_cnt  <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            frame_q   <= frame_bus.frame_in;
            colour_q  <= cell_colour(frame_bus.frame_in[CELLS-1], ALIVE_GRB, DEAD_GRB);
            pixel_idx <= '0;
            bit_idx   <= BIT_W'(BITS_PER_PIXEL - 1);
          end
        end
        BIT: begin
          if (bit_last) begin
            if (!last_bit_of_pixel) begin
              bit_idx <= bit_idx - BIT_W'(1);
            end else if (!last_pixel) begin
              pixel_idx <= pixel_idx + PIX_W'(1);
              colour_q  <= cell_colour(frame_q[next_sel], ALIVE_GRB, DEAD_GRB);
              bit_idx   <= BIT_W'(BITS_PER_PIXEL - 1);
            end
          end
        end
        LATCH:   latch_cnt <= latch_cnt + LATCH_W'(1);
        HOLD:    hold_cnt  <= hold_cnt + HOLD_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_frame_streamer.sv
// Bench for life_frame_streamer: decodes the WS2812 line back into bits and
// pixels, compares each bit against a queue of expected bits pushed when a
// frame is accepted, and checks handshake, reset and frame_done timing.
module tb_life_frame_streamer;
  import life_frame_streamer_pkg::*;

  localparam int T_BIT          = 15;
  localparam int T0H            = 4;
  localparam int T1H            = 10;
  localparam int T_LATCH        = 20;
  localparam int HOLD_CYC       = 5;
  localparam int BITS_PER_FRAME = CELLS * BITS_PER_PIXEL;
  localparam int EXP_LATENCY    = 1 + BITS_PER_FRAME * T_BIT + T_LATCH + HOLD_CYC;
  localparam logic [23:0] ALIVE_C = 24'h00_10_00;
  localparam logic [23:0] DEAD_C  = 24'h00_00_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led_dout;
  logic busy;
  logic frame_done;

  life_frame_streamer_if frame_bus ();

  life_frame_streamer #(
    .T_BIT     (T_BIT),
    .T0H       (T0H),
    .T1H       (T1H),
    .T_LATCH   (T_LATCH),
    .HOLD_CYC  (HOLD_CYC),
    .ALIVE_GRB (ALIVE_C),
    .DEAD_GRB  (DEAD_C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_bus  (frame_bus),
    .led_dout   (led_dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cycleCnt = 0;
  int          acceptCycle = 0;
  bit          acceptValid = 1'b0;
  int          doneCount = 0;
  logic        expBits[$];

  logic        prevLed = 1'b0;
  int          hiLen = 0;
  int          sinceRise = 0;
  int          frameBits = 0;
  logic [23:0] pixShift = '0;
  logic [63:0] decodedFrame = '0;
  logic [63:0] lastDecoded = '0;
  logic        prevDone = 1'b0;
  bit          expectReadyNext = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] cellMask(input int r, input int c);
    logic [63:0] m;
    m = 64'd1;
    return m << (63 - (r * GRID_DIM + c));
  endfunction

  task automatic pushFrame(input logic [63:0] f);
    logic [23:0] colour;
    for (int p = 0; p < CELLS; p++) begin
      colour = f[63 - p] ? ALIVE_C : DEAD_C;
      for (int b = BITS_PER_PIXEL - 1; b >= 0; b--) expBits.push_back(colour[b]);
    end
  endtask

  task automatic decodeBit(input int width);
    logic expBit;
    logic gotBit;
    if (expBits.size() == 0) begin
      checkOutput("extraBit", 64'd1, 64'd0);
    end else begin
      expBit = expBits.pop_front();
      checkOutput("bitWidth", 64'(width), expBit ? 64'(T1H) : 64'(T0H));
    end
    gotBit = (width == T1H);
    pixShift = {pixShift[22:0], gotBit};
    frameBits++;
    if (frameBits % BITS_PER_PIXEL == 0) decodedFrame = {decodedFrame[62:0], pixShift == ALIVE_C};
    if (frameBits == BITS_PER_FRAME) begin
      lastDecoded = decodedFrame;
      frameBits = 0;
    end
  endtask

  // Present a frame (caller is at a negedge) and wait for it to be taken
  task automatic applyStimulus(input logic [63:0] f);
    bit accepted = 1'b0;
    frame_bus.frame_in    = f;
    frame_bus.frame_valid = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      if (frame_bus.frame_ready && rst_n) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      checkOutput("acceptTimeout", 64'd0, 64'd1);
      frame_bus.frame_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acceptCycle = cycleCnt;
      acceptValid = 1'b1;
      pushFrame(f);
      frame_bus.frame_valid = 1'b0;
    end
  endtask

  task automatic waitDone();
    int  startDone = doneCount;
    bit  seen = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (doneCount != startDone) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("doneTimeout", 64'd0, 64'd1);
  endtask

  // Free-running cycle counter used for latency measurement
  always @(posedge clk) cycleCnt++;

  // Decode the serial line into bit widths and compare against the queue
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prevLed   = 1'b0;
      hiLen     = 0;
      sinceRise = 0;
      frameBits = 0;
    end else begin
      if (led_dout && !prevLed) begin
        if (frameBits != 0) checkOutput("bitPeriod", 64'(sinceRise), 64'(T_BIT));
        sinceRise = 1;
        hiLen     = 1;
      end else begin
        sinceRise++;
        if (led_dout) hiLen++;
      end
      if (!led_dout && prevLed) decodeBit(hiLen);
      prevLed = led_dout;
    end
  end

  // Watch frame_done: width, latency from acceptance and ready afterwards
  always @(posedge clk) begin
    #1;
    if (expectReadyNext) begin
      checkOutput("readyAfterDone", 64'(frame_bus.frame_ready), 64'd1);
      expectReadyNext = 1'b0;
    end
    if (frame_done) begin
      doneCount++;
      checkOutput("doneWidth", 64'(prevDone), 64'd0);
      checkOutput("readyDuringDone", 64'(frame_bus.frame_ready), 64'd0);
      if (acceptValid) checkOutput("doneLatency", 64'(cycleCnt - acceptCycle), 64'(EXP_LATENCY));
      else checkOutput("spuriousDone", 64'd1, 64'd0);
      expectReadyNext = 1'b1;
    end
    prevDone = frame_done;
  end

  // Hard stop in case the design locks up somewhere unbounded
  initial begin
    repeat (120000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] blinkH;
    logic [63:0] blinkV;
    logic [63:0] randFrame;
    logic [63:0] decH;
    logic [63:0] decV;
    int          doneBefore;
    bit          reached;

    blinkH = cellMask(3, 2) | cellMask(3, 3) | cellMask(3, 4);
    blinkV = cellMask(2, 3) | cellMask(3, 3) | cellMask(4, 3);

    // Reset held while a frame is already being offered
    frame_bus.frame_in    = 64'h8000_0000_0000_0000;
    frame_bus.frame_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReady", 64'(frame_bus.frame_ready), 64'd1);
    checkOutput("rstLed", 64'(led_dout), 64'd0);
    checkOutput("rstDone", 64'(frame_done), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] single live cell frame");
    applyStimulus(64'h8000_0000_0000_0000);
    checkOutput("acceptNoDelay", 64'(cycleCnt), 64'(acceptCycle));
    checkOutput("busyAfterAccept", 64'(busy), 64'd1);
    checkOutput("readyAfterAccept", 64'(frame_bus.frame_ready), 64'd0);
    checkOutput("ledAtAccept", 64'(led_dout), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("firstRise", 64'(led_dout), 64'd1);

    // Wiggle the bus mid-frame; none of it may be taken
    repeat (200) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      frame_bus.frame_in    = {$urandom, $urandom};
      frame_bus.frame_valid = i[0];
      checkOutput("readyInBit", 64'(frame_bus.frame_ready), 64'd0);
      @(negedge clk);
    end
    frame_bus.frame_valid = 1'b0;
    waitDone();
    checkOutput("frameSingle", lastDecoded, 64'h8000_0000_0000_0000);
    checkOutput("queueAfterSingle", 64'(expBits.size()), 64'd0);

    // All cells alive: every bit is a long pulse
    $display("[TB] all-alive frame");
    @(negedge clk);
    applyStimulus({64{1'b1}});
    waitDone();
    checkOutput("frameOnes", lastDecoded, {64{1'b1}});
    checkOutput("doneCountOnes", 64'(doneCount), 64'd2);

    // Abort a frame partway through with reset
    $display("[TB] reset mid-frame");
    randFrame = {$urandom, $urandom};
    @(negedge clk);
    applyStimulus(randFrame);
    reached = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (frameBits >= 700) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("reachBit700", 64'(reached), 64'd1);
    for (int i = 0; i < 2 * T_BIT; i++) begin
      if (led_dout) break;
      @(negedge clk);
    end
    checkOutput("ledHighBeforeAbort", 64'(led_dout), 64'd1);
    doneBefore = doneCount;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abortLed", 64'(led_dout), 64'd0);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortReady", 64'(frame_bus.frame_ready), 64'd1);
    checkOutput("abortDone", 64'(frame_done), 64'd0);
    expBits.delete();
    acceptValid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("noDoneAfterAbort", 64'(doneCount), 64'(doneBefore));
    checkOutput("idleAfterAbort", 64'(busy), 64'd0);

    // Blinker with frame_done feeding the next generation straight back
    $display("[TB] blinker loop");
    applyStimulus(blinkH);
    waitDone();
    decH = lastDecoded;
    checkOutput("blinkerH", decH, blinkH);
    applyStimulus(blinkV);
    checkOutput("reacceptDelay", 64'(cycleCnt - 1), 64'(acceptCycle - 1));
    waitDone();
    decV = lastDecoded;
    checkOutput("blinkerV", decV, blinkV);
    checkOutput("blinkerAlternates", 64'(decH != decV), 64'd1);

    checkOutput("queueEmpty", 64'(expBits.size()), 64'd0);
    checkOutput("totalDone", 64'(doneCount), 64'd4);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
